// File: rtl/spell_mem_pkg.sv
// Shared types and constants for the spell memory arbiter slice.
package spell_mem_pkg;

    localparam int   DEF_ADDR_W = 8;
    localparam int   DEF_DATA_W = 8;
    localparam logic PORT_A     = 1'b0;
    localparam logic PORT_B     = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_e;

endpackage

// File: rtl/spell_mem_arbiter_if.sv
// Requester ports A/B plus the spell memory handshake, bundled as one interface.
interface spell_mem_arbiter_if
    import spell_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data_in;
    logic              a_memory_type_data;
    logic              a_write;
    logic [DATA_W-1:0] a_data_out;
    logic              a_ack;
    logic              a_error;

    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data_in;
    logic              b_memory_type_data;
    logic              b_write;
    logic [DATA_W-1:0] b_data_out;
    logic              b_ack;
    logic              b_error;

    logic              mem_select;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_memory_type_data;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_data_ready;

    logic              busy;
    logic              grant_b;

    // Arbiter side
    modport master (
        input  a_req, a_addr, a_data_in, a_memory_type_data, a_write,
        output a_data_out, a_ack, a_error,
        input  b_req, b_addr, b_data_in, b_memory_type_data, b_write,
        output b_data_out, b_ack, b_error,
        output mem_select, mem_addr, mem_data_in, mem_memory_type_data, mem_write,
        input  mem_data_out, mem_data_ready,
        output busy, grant_b
    );

    // Requesters and memory side
    modport slave (
        output a_req, a_addr, a_data_in, a_memory_type_data, a_write,
        input  a_data_out, a_ack, a_error,
        output b_req, b_addr, b_data_in, b_memory_type_data, b_write,
        input  b_data_out, b_ack, b_error,
        input  mem_select, mem_addr, mem_data_in, mem_memory_type_data, mem_write,
        output mem_data_out, mem_data_ready,
        input  busy, grant_b
    );

endinterface

// File: rtl/spell_rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the port that did not own last wins.
module spell_rr_arb2
    import spell_mem_pkg::*;
(
    input  logic a_req_i,
    input  logic b_req_i,
    input  logic grant_b_i,
    output logic vld_o,
    output logic pick_b_o
);

    assign vld_o    = a_req_i | b_req_i;
    assign pick_b_o = b_req_i & (~a_req_i | (grant_b_i == PORT_A));

endmodule

// File: rtl/spell_mem_arbiter.sv
// Two-port arbiter/sequencer for the spell memory select/data_ready handshake,
// with a watchdog that aborts accesses the memory never completes.
module spell_mem_arbiter
    import spell_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    spell_mem_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_q, sel_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               type_q, type_d;
    logic               write_q, write_d;
    logic [DATA_W-1:0]  a_dout_q, a_dout_d, b_dout_q, b_dout_d;
    logic               a_ack_q, a_ack_d, a_err_q, a_err_d;
    logic               b_ack_q, b_ack_d, b_err_q, b_err_d;
    logic               busy_q, busy_d;
    logic               grant_b_q, grant_b_d;

    logic               pick_vld, pick_b;
    logic               done, timed_out;
    logic [DATA_W-1:0]  rd_val;

    spell_rr_arb2 u_arb (
        .a_req_i   (bus.a_req),
        .b_req_i   (bus.b_req),
        .grant_b_i (grant_b_q),
        .vld_o     (pick_vld),
        .pick_b_o  (pick_b)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            type_q    <= 1'b0;
            write_q   <= 1'b0;
            a_dout_q  <= '0;
            b_dout_q  <= '0;
            a_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            b_err_q   <= 1'b0;
            busy_q    <= 1'b0;
            grant_b_q <= PORT_B;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            type_q    <= type_d;
            write_q   <= write_d;
            a_dout_q  <= a_dout_d;
            b_dout_q  <= b_dout_d;
            a_ack_q   <= a_ack_d;
            a_err_q   <= a_err_d;
            b_ack_q   <= b_ack_d;
            b_err_q   <= b_err_d;
            busy_q    <= busy_d;
            grant_b_q <= grant_b_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        type_d    = type_q;
        write_d   = write_q;
        a_dout_d  = a_dout_q;
        b_dout_d  = b_dout_q;
        a_ack_d   = 1'b0;
        a_err_d   = 1'b0;
        b_ack_d   = 1'b0;
        b_err_d   = 1'b0;
        grant_b_d = grant_b_q;
        // Data ready wins over the watchdog when both land on the same cycle
        timed_out = !bus.mem_data_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
        done      = bus.mem_data_ready || timed_out;
        rd_val    = bus.mem_data_ready ? bus.mem_data_out : '0;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_b_d = pick_b ? PORT_B : PORT_A;
                    addr_d    = pick_b ? bus.b_addr : bus.a_addr;
                    wdata_d   = pick_b ? bus.b_data_in : bus.a_data_in;
                    type_d    = pick_b ? bus.b_memory_type_data : bus.a_memory_type_data;
                    write_d   = pick_b ? bus.b_write : bus.a_write;
                    sel_d     = 1'b1;
                    cnt_d     = '0;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done) begin
                    sel_d   = 1'b0;
                    state_d = RESPOND;
                    if (grant_b_q == PORT_B) begin
                        b_ack_d = 1'b1;
                        b_err_d = timed_out;
                        if (!write_q) b_dout_d = rd_val;
                    end else begin
                        a_ack_d = 1'b1;
                        a_err_d = timed_out;
                        if (!write_q) a_dout_d = rd_val;
                    end
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.mem_select           = sel_q;
    assign bus.mem_addr             = addr_q;
    assign bus.mem_data_in          = wdata_q;
    assign bus.mem_memory_type_data = type_q;
    assign bus.mem_write            = write_q;
    assign bus.a_data_out           = a_dout_q;
    assign bus.a_ack                = a_ack_q;
    assign bus.a_error              = a_err_q;
    assign bus.b_data_out           = b_dout_q;
    assign bus.b_ack                = b_ack_q;
    assign bus.b_error              = b_err_q;
    assign bus.busy                 = busy_q;
    assign bus.grant_b              = grant_b_q;

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Bench for spell_mem_arbiter: latency-programmable memory model plus a
// transaction-level reference for ownership, outcome and returned data.
module tb_spell_mem_arbiter;
    import spell_mem_pkg::*;

    localparam int TIMEOUT = 15;

    logic clock = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    int   mem_lat = 0;

    logic [7:0] store   [2][256];
    logic [7:0] ref_mem [2][256];
    logic [7:0] ref_dout [2];
    bit         last_b = 1'b1;
    bit         req_on [2];
    logic [7:0] p_addr [2];
    logic [7:0] p_data [2];
    bit         p_typ  [2];
    bit         p_wr   [2];

    spell_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    spell_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] init_val(int t, int a);
        return 8'((a * 37 + t * 91 + 13) & 255);
    endfunction

    // Memory: raises data_ready mem_lat cycles after select (0 = never answers)
    initial begin : mem_model
        int mcnt;
        mcnt = 0;
        for (int t = 0; t < 2; t++)
            for (int a = 0; a < 256; a++)
                store[t][a] = init_val(t, a);
        bus.mem_data_ready <= 1'b0;
        bus.mem_data_out   <= 8'h00;
        forever begin
            @(posedge clock);
            if (!reset_n || !bus.mem_select) begin
                bus.mem_data_ready <= 1'b0;
                mcnt = 0;
            end else if (!bus.mem_data_ready) begin
                mcnt++;
                if (mem_lat != 0 && mcnt == mem_lat - 1) begin
                    bus.mem_data_ready <= 1'b1;
                    bus.mem_data_out   <= store[bus.mem_memory_type_data][bus.mem_addr];
                    if (bus.mem_write)
                        store[bus.mem_memory_type_data][bus.mem_addr] = bus.mem_data_in;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit p, input logic [7:0] addr, input logic [7:0] data,
                           input bit typ, input bit wr);
        p_addr[p] = addr;
        p_data[p] = data;
        p_typ[p]  = typ;
        p_wr[p]   = wr;
        req_on[p] = 1'b1;
        if (p) begin
            bus.b_addr = addr; bus.b_data_in = data;
            bus.b_memory_type_data = typ; bus.b_write = wr; bus.b_req = 1'b1;
        end else begin
            bus.a_addr = addr; bus.a_data_in = data;
            bus.a_memory_type_data = typ; bus.a_write = wr; bus.a_req = 1'b1;
        end
    endtask

    task automatic drop_req(input bit p);
        req_on[p] = 1'b0;
        if (p) bus.b_req = 1'b0;
        else   bus.a_req = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        drop_req(0);
        drop_req(1);
        ref_dout[0] = 8'h00;
        ref_dout[1] = 8'h00;
        last_b = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    // One transaction from the current request set; ends on the IDLE-cycle negedge
    task automatic do_txn(input int lat, input bit drop_early);
        bit owner, ok, got;
        int sel_cnt, bad;
        owner = (req_on[0] && req_on[1]) ? !last_b : req_on[1];
        ok    = (lat != 0) && (lat <= TIMEOUT);
        mem_lat = lat;
        if (p_wr[owner]) begin
            if (ok) ref_mem[p_typ[owner]][p_addr[owner]] = p_data[owner];
        end else begin
            ref_dout[owner] = ok ? ref_mem[p_typ[owner]][p_addr[owner]] : 8'h00;
        end
        got = 1'b0; sel_cnt = 0; bad = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clock);
            if (bus.a_ack || bus.b_ack) got = 1'b1;
            else if (bus.mem_select) begin
                sel_cnt++;
                if (bus.mem_addr !== p_addr[owner] || bus.mem_write !== p_wr[owner] ||
                    bus.mem_memory_type_data !== p_typ[owner] ||
                    (p_wr[owner] && bus.mem_data_in !== p_data[owner]))
                    bad++;
                if (drop_early && sel_cnt == 2) drop_req(owner);
            end
        end
        chk("ack_seen",   got, 1);
        chk("sel_cycles", sel_cnt, ok ? lat : TIMEOUT);
        chk("mem_fields", bad, 0);
        chk("owner_ack",  owner ? bus.b_ack : bus.a_ack, 1);
        chk("other_ack",  owner ? bus.a_ack : bus.b_ack, 0);
        chk("owner_err",  owner ? bus.b_error : bus.a_error, !ok);
        chk("other_err",  owner ? bus.a_error : bus.b_error, 0);
        chk("a_dout",     bus.a_data_out, ref_dout[0]);
        chk("b_dout",     bus.b_data_out, ref_dout[1]);
        chk("sel_at_ack", bus.mem_select, 0);
        chk("busy_resp",  bus.busy, 1);
        chk("grant_b",    bus.grant_b, owner);
        last_b = owner;
        if (req_on[owner]) drop_req(owner);
        @(negedge clock);
        chk("ack_pulse",  bus.a_ack | bus.b_ack, 0);
        chk("sel_gap",    bus.mem_select, 0);
        chk("busy_idle",  bus.busy, 0);
        chk("a_dout_hold", bus.a_data_out, ref_dout[0]);
        chk("b_dout_hold", bus.b_data_out, ref_dout[1]);
    endtask

    initial begin : stimulus
        int pa, lat;
        bus.a_req = 1'b0; bus.a_addr = '0; bus.a_data_in = '0;
        bus.a_memory_type_data = 1'b0; bus.a_write = 1'b0;
        bus.b_req = 1'b0; bus.b_addr = '0; bus.b_data_in = '0;
        bus.b_memory_type_data = 1'b0; bus.b_write = 1'b0;
        for (int t = 0; t < 2; t++)
            for (int a = 0; a < 256; a++)
                ref_mem[t][a] = init_val(t, a);

        apply_reset();
        chk("rst_sel",   bus.mem_select, 0);
        chk("rst_addr",  bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_data_in, 0);
        chk("rst_type",  bus.mem_memory_type_data, 0);
        chk("rst_write", bus.mem_write, 0);
        chk("rst_adout", bus.a_data_out, 0);
        chk("rst_bdout", bus.b_data_out, 0);
        chk("rst_acks",  {bus.a_ack, bus.b_ack, bus.a_error, bus.b_error}, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_grant", bus.grant_b, 1);
        reset_n = 1'b1;

        // A write code[5] = 3C, then read it back
        set_req(PORT_A, 8'h05, 8'h3C, 1'b0, 1'b1);
        do_txn(4, 1'b0);
        set_req(PORT_A, 8'h05, 8'h00, 1'b0, 1'b0);
        do_txn(3, 1'b0);
        chk("read_3c", bus.a_data_out, 8'h3C);

        // Simultaneous requests after reset alternate A, B, A, B
        apply_reset();
        reset_n = 1'b1;
        set_req(PORT_A, 8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom), 1'($urandom));
        set_req(PORT_B, 8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom), 1'($urandom));
        for (int k = 0; k < 4; k++) begin
            do_txn(2 + k, 1'b0);
            chk("alt_order", bus.grant_b, k % 2);
            set_req(last_b, 8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        drop_req(0);
        drop_req(1);

        // B read succeeds, then times out (data cleared), then A is served normally
        set_req(PORT_B, 8'h21, 8'h00, 1'b1, 1'b0);
        do_txn(5, 1'b0);
        set_req(PORT_B, 8'h22, 8'h00, 1'b1, 1'b0);
        do_txn(0, 1'b0);
        chk("tmo_bdout", bus.b_data_out, 8'h00);
        set_req(PORT_A, 8'h30, 8'h00, 1'b1, 1'b0);
        do_txn(2, 1'b0);

        // data_ready coincides with the last watchdog cycle
        set_req(PORT_A, 8'h07, 8'h00, 1'b1, 1'b0);
        do_txn(TIMEOUT, 1'b0);

        // Randomised mix of ports, directions, latencies and early request drops
        for (int k = 0; k < 24; k++) begin
            drop_req(0);
            drop_req(1);
            pa = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++)
                if (pa[p])
                    set_req(p[0], 8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom), 1'($urandom));
            lat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(2, TIMEOUT);
            do_txn(lat, $urandom_range(0, 3) == 0);
        end
        drop_req(0);
        drop_req(1);

        // Reset in the middle of an access
        set_req(PORT_B, 8'h09, 8'h00, 1'b0, 1'b0);
        mem_lat = 0;
        repeat (3) @(negedge clock);
        chk("mid_sel", bus.mem_select, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_sel",   bus.mem_select, 0);
        chk("mid_rst_ack",   bus.a_ack | bus.b_ack, 0);
        chk("mid_rst_grant", bus.grant_b, 1);
        chk("mid_rst_busy",  bus.busy, 0);
        apply_reset();
        chk("mid_rst_noack", bus.a_ack | bus.b_ack, 0);
        reset_n = 1'b1;
        set_req(PORT_A, 8'h0A, 8'h00, 1'b0, 1'b0);
        set_req(PORT_B, 8'h0B, 8'h00, 1'b1, 1'b0);
        do_txn(3, 1'b0);
        chk("tie_after_rst", bus.grant_b, 0);
        drop_req(0);
        drop_req(1);
        repeat (2) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
